// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one external pipelined divider among NREQ requesters,
// tracking in-flight operations with a tag pipeline and per-requester credit counters.
module div_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DIV_LAT = 33,
  parameter int MAXOUT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_z,
  input  logic [NREQ*WIDTH-1:0]  req_d,
  output logic [WIDTH-1:0]       div_z,
  output logic [WIDTH-1:0]       div_d,
  input  logic [WIDTH-1:0]       div_quot,
  input  logic [WIDTH-1:0]       div_rem,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [WIDTH-1:0]       res_quot,
  output logic [WIDTH-1:0]       res_rem,
  output logic                   res_dz,
  output logic                   busy
);

  localparam int CW   = $clog2(MAXOUT) + 1;
  // One stage for the operand register plus DIV_LAT+1 stages that line up with the divider output.
  localparam int TAGS = DIV_LAT + 2;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           dz;
  } tag_t;

  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [NREQ-1:0][CW-1:0]   cnt_q, cnt_d;
  tag_t [TAGS-1:0]           tag_q, tag_d;
  logic [WIDTH-1:0]          div_z_q, div_z_d;
  logic [WIDTH-1:0]          div_d_q, div_d_d;

  logic [NREQ-1:0]           ret;
  logic [NREQ-1:0]           elig;
  logic [NREQ-1:0]           grant;
  logic                      found;
  logic [IDW-1:0]            gnt_id;
  logic [WIDTH-1:0]          sel_z;
  logic [WIDTH-1:0]          sel_d;
  tag_t                      tag_out;

  assign tag_out = tag_q[TAGS-1];

  // A credit returning this cycle frees its slot immediately, so a full requester can re-issue at once.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    ret  = '0;
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      ret[i]  = tag_out.valid && (tag_out.id == IDW'(i));
      elig[i] = rst && req_valid[i] && ((cnt_q[i] < CW'(MAXOUT)) || ret[i]);
    end
  end

  always_comb begin : grant_search
    int idx;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  assign grant     = found ? (NREQ'(1) << gnt_id) : '0;
  assign req_ready = grant;
  assign sel_z     = req_z[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_d     = req_d[int'(gnt_id)*WIDTH +: WIDTH];

  always_comb begin
    ptr_d   = ptr_q;
    div_z_d = div_z_q;
    div_d_d = div_d_q;
    cnt_d   = cnt_q;
    tag_d   = '0;

    tag_d[0].valid = found;
    tag_d[0].id    = gnt_id;
    tag_d[0].dz    = (sel_d == '0);
    for (int k = 1; k < TAGS; k++) tag_d[k] = tag_q[k-1];

    if (found) begin
      ptr_d   = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
      div_z_d = sel_z;
      div_d_d = sel_d;
    end

    for (int i = 0; i < NREQ; i++) begin
      case ({grant[i], ret[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ptr_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      div_z_q <= '0;
      div_d_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      div_z_q <= div_z_d;
      div_d_q <= div_d_d;
    end
  end

  assign div_z     = div_z_q;
  assign div_d     = div_d_q;
  assign res_valid = tag_out.valid;
  assign res_id    = tag_out.valid ? tag_out.id : '0;
  assign res_dz    = tag_out.valid && tag_out.dz;
  assign res_quot  = !tag_out.valid ? '0 : (tag_out.dz ? '1 : div_quot);
  assign res_rem   = (tag_out.valid && !tag_out.dz) ? div_rem : '0;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < TAGS; k++) busy = busy | tag_q[k].valid;
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter with a behavioural pipelined divider model;
// issues are logged at the handshake and a separate monitor checks every result.
module tb_div_share_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int DL = 9;
  localparam int MO = 4;

  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } op_t;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [31:0]  cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_z;
  logic [N*W-1:0] req_d;
  logic [W-1:0]   div_z, div_d, div_quot, div_rem;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [W-1:0]   res_quot, res_rem;
  logic           res_dz;
  logic           busy;

  div_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(2), .DIV_LAT(DL), .MAXOUT(MO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_z(req_z), .req_d(req_d),
    .div_z(div_z), .div_d(div_d), .div_quot(div_quot), .div_rem(div_rem),
    .res_valid(res_valid), .res_id(res_id), .res_quot(res_quot), .res_rem(res_rem),
    .res_dz(res_dz), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider model: DL+1 register stages from div_z/div_d to div_quot/div_rem.
  logic [2*W-1:0] pq [DL+1];
  always @(posedge clk) begin
    for (int k = DL; k > 0; k--) pq[k] <= pq[k-1];
    pq[0] <= (div_d == '0) ? {8'hA5, div_z} : {div_z / div_d, div_z % div_d};
  end
  assign div_quot = pq[DL][2*W-1:W];
  assign div_rem  = pq[DL][W-1:0];

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc   = 0;
  op_t    reqq [N][$];
  exp_t   sb [$];
  int     glog [$];
  int     gcyc [$];
  logic [N-1:0] hs_last = '0;
  op_t    hs_op;
  exp_t   hs_exp;
  exp_t   mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk(input logic [W-1:0] z, d, q, r);
    op_t o;
    o.z = z; o.d = d; o.q = q; o.r = r;
    return o;
  endfunction

  function automatic op_t mk_auto(input logic [W-1:0] z, d);
    return mk(z, d, z / d, z % d);
  endfunction

  function automatic bit all_empty();
    bit e = (sb.size() == 0);
    for (int i = 0; i < N; i++) if (reqq[i].size() != 0) e = 0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Driver: present the head of each requester queue, advance after a handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_last[i] && reqq[i].size() > 0) void'(reqq[i].pop_front());
      hs_last[i] = 1'b0;
      if (reqq[i].size() > 0) begin
        req_valid[i]     = 1'b1;
        req_z[i*W +: W]  = reqq[i][0].z;
        req_d[i*W +: W]  = reqq[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Issue logger: pushes the expected response at each handshake.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i] && reqq[i].size() > 0) begin
          hs_op      = reqq[i][0];
          hs_exp.id  = 2'(i);
          hs_exp.q   = hs_op.q;
          hs_exp.r   = hs_op.r;
          hs_exp.dz  = (hs_op.d == '0);
          hs_exp.cyc = 32'(cyc);
          sb.push_back(hs_exp);
          glog.push_back(i);
          gcyc.push_back(cyc);
          hs_last[i] = 1'b1;
        end
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_exp = sb.pop_front();
          check("result_id_quot_rem_dz", {res_id, res_quot, res_rem, res_dz},
                {mon_exp.id, mon_exp.q, mon_exp.r, mon_exp.dz});
          check("result_latency", 64'(cyc), 64'(mon_exp.cyc + DL + 2));
        end
      end else begin
        check("idle_outputs_zero", {res_id, res_quot, res_rem, res_dz}, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (!all_empty()) begin
      step();
      n++;
      if (n > budget) begin
        check({name, "_timeout"}, 1, 0);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {req_ready, div_z, div_d, res_valid, res_id, res_quot, res_rem, res_dz, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gaps [6];
    int rv_cnt;
    int n;
    gaps = '{0, 1, 2, 3, 11, 12};
    rst = 1'b1;
    req_valid = '0;
    req_z = '0;
    req_d = '0;
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    // Single op, fixed latency, busy drops after the result.
    reqq[1].push_back(mk(8'd100, 8'd7, 8'd14, 8'd2));
    drain(40, "single");
    check("busy_during_result", busy, 1);
    step();
    check("busy_after_result", busy, 0);

    // Four continuous streams: round robin from pointer 2 (last grant was requester 1).
    glog.delete(); gcyc.delete();
    reqq[0].push_back(mk(8'd50,  8'd5,  8'd10, 8'd0));
    reqq[0].push_back(mk(8'd255, 8'd16, 8'd15, 8'd15));
    reqq[0].push_back(mk(8'd9,   8'd10, 8'd0,  8'd9));
    reqq[1].push_back(mk(8'd81,  8'd9,  8'd9,  8'd0));
    reqq[1].push_back(mk(8'd100, 8'd3,  8'd33, 8'd1));
    reqq[1].push_back(mk(8'd1,   8'd1,  8'd1,  8'd0));
    reqq[2].push_back(mk(8'd240, 8'd7,  8'd34, 8'd2));
    reqq[2].push_back(mk(8'd13,  8'd13, 8'd1,  8'd0));
    reqq[2].push_back(mk(8'd200, 8'd201, 8'd0, 8'd200));
    reqq[3].push_back(mk(8'd128, 8'd2,  8'd64, 8'd0));
    reqq[3].push_back(mk(8'd99,  8'd4,  8'd24, 8'd3));
    reqq[3].push_back(mk(8'd250, 8'd25, 8'd10, 8'd0));
    drain(80, "rr_stream");
    check("rr_grant_count", glog.size(), 12);
    if (glog.size() == 12) begin
      for (int k = 0; k < 12; k++) check("rr_grant_order", glog[k], (2 + k) % 4);
      for (int k = 1; k < 12; k++) check("rr_grant_back_to_back", gcyc[k] - gcyc[k-1], 1);
    end

    // Divide by zero between neighbouring ops.
    reqq[1].push_back(mk(8'd200, 8'd9, 8'd22,  8'd2));
    reqq[2].push_back(mk(8'd55,  8'd0, 8'hFF,  8'd0));
    reqq[3].push_back(mk(8'd77,  8'd5, 8'd15,  8'd2));
    drain(60, "div_zero");

    // Credit limit: four grants, stall, resume on the cycle the first result returns.
    glog.delete(); gcyc.delete();
    reqq[0].push_back(mk(8'd10, 8'd3, 8'd3, 8'd1));
    reqq[0].push_back(mk(8'd20, 8'd3, 8'd6, 8'd2));
    reqq[0].push_back(mk(8'd30, 8'd4, 8'd7, 8'd2));
    reqq[0].push_back(mk(8'd40, 8'd6, 8'd6, 8'd4));
    reqq[0].push_back(mk(8'd50, 8'd7, 8'd7, 8'd1));
    reqq[0].push_back(mk(8'd60, 8'd8, 8'd7, 8'd4));
    drain(80, "credit");
    check("credit_grant_count", glog.size(), 6);
    if (glog.size() == 6)
      for (int k = 0; k < 6; k++) check("credit_grant_cycle", gcyc[k] - gcyc[0], gaps[k]);

    // Reset mid-stream with five operations in flight.
    for (int i = 0; i < N; i++) begin
      reqq[i].push_back(mk_auto(8'(30 + 20*i), 8'(3 + i)));
      reqq[i].push_back(mk_auto(8'(31 + 20*i), 8'(4 + i)));
    end
    n = 0;
    while (sb.size() < 5 && n < 40) begin
      step();
      n++;
    end
    check("reset_inflight_count", sb.size(), 5);
    rst = 1'b0;
    for (int i = 0; i < N; i++) reqq[i].delete();
    sb.delete();
    #1 check_reset_outputs("reset_midstream_outputs");
    repeat (3) step();
    rst = 1'b1;
    rv_cnt = 0;
    repeat (DL + 5) begin
      step();
      if (res_valid) rv_cnt++;
    end
    check("no_result_after_reset", rv_cnt, 0);
    glog.delete(); gcyc.delete();
    for (int i = 0; i < N; i++) reqq[i].push_back(mk_auto(8'(200 - i), 8'(7 + i)));
    drain(60, "post_reset");
    check("post_reset_grant_count", glog.size(), 4);
    if (glog.size() == 4)
      for (int k = 0; k < 4; k++) check("post_reset_grant_order", glog[k], k);

    // Random operands from mixed requesters.
    for (int k = 0; k < 2000; k++)
      reqq[$urandom_range(0, N-1)].push_back(mk_auto(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255))));
    drain(8000, "random");
    step();
    check("busy_idle_end", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
